// File: rtl/press_classifier.sv
// Turns the debounced button level into short, long and double press pulses.
// Pulses are one cycle wide, registered, and mutually exclusive.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for a fresh rising edge on db_level
// PRESS1    | first press held, counting toward the long-press threshold
// GAP       | first press released, counting the double-press window
// PRESS2    | second press seen (double already reported), wait for release
// LONG_HOLD | long press reported, wait for release
module press_classifier #(
  parameter int CNT_W    = 16,
  parameter int LONG_CYC = 50000,
  parameter int DBL_CYC  = 15000
) (
  input  logic clk,
  input  logic reset,
  input  logic db_level,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic held,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    GAP       = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             prev_level;
  logic             short_d, long_d, double_d, held_d, busy_d;

  // prev_level resets high so a button held through reset is not a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      prev_level   <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      held         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      prev_level   <= db_level;
      short_press  <= short_d;
      long_press   <= long_d;
      double_press <= double_d;
      held         <= held_d;
      busy         <= busy_d;
    end
  end

  // Level tests come before terminal-count tests in every state.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (db_level && !prev_level) begin
          state_d = PRESS1;
          cnt_d   = '0;
        end
      end
      PRESS1: begin
        if (!db_level) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt == LONG_TC) begin
          state_d = LONG_HOLD;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      GAP: begin
        if (db_level) begin
          state_d = PRESS2;
        end else if (cnt == DBL_TC) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESS2: begin
        if (!db_level) state_d = IDLE;
      end
      LONG_HOLD: begin
        if (!db_level) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    short_d  = (state == GAP) && !db_level && (cnt == DBL_TC);
    long_d   = (state == PRESS1) && db_level && (cnt == LONG_TC);
    double_d = (state == GAP) && db_level;
    held_d   = (state_d == LONG_HOLD);
    busy_d   = (state_d != IDLE);
  end

endmodule

// File: tb/tb_press_classifier.sv
// Bench for press_classifier: gesture table, hand-written reset corner cases
// and a long random run, all checked cycle by cycle against a run-length model.
module tb_press_classifier;

  localparam int LONG_CYC = 8;
  localparam int DBL_CYC  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic db_level = 1'b0;
  logic short_press, long_press, double_press, held, busy;

  always #5 clk = ~clk;

  press_classifier #(
    .CNT_W   (16),
    .LONG_CYC(LONG_CYC),
    .DBL_CYC (DBL_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db_level    (db_level),
    .short_press (short_press),
    .long_press  (long_press),
    .double_press(double_press),
    .held        (held),
    .busy        (busy)
  );

  typedef struct packed {
    logic s;
    logic l;
    logic d;
    logic h;
    logic b;
  } exp_t;

  typedef enum int {M_IDLE, M_P1, M_GAP, M_P2, M_HOLD} mphase_t;

  typedef struct {
    string name;
    int    hi1, lo1, hi2, lo2;
    int    exp_s, exp_l, exp_d;
  } vec_t;

  int errors = 0;
  int checks = 0;
  int n_short = 0, n_long = 0, n_double = 0;
  int m_short = 0, m_long = 0, m_double = 0;
  int any_busy;
  exp_t    sb_q[$];
  mphase_t m_ph = M_IDLE;
  int      m_run = 0;
  logic    m_prev = 1'b1;
  vec_t    vecs[8];

  // Model in terms of samples seen: a long press needs LONG_CYC+1 high samples,
  // a short press needs DBL_CYC+1 low samples after release.
  task automatic model(input logic lvl, input logic rst, output exp_t e);
    e = '0;
    if (rst) begin
      m_ph   = M_IDLE;
      m_run  = 0;
      m_prev = 1'b1;
    end else begin
      case (m_ph)
        M_IDLE: if (lvl && !m_prev) begin m_ph = M_P1; m_run = 1; end
        M_P1: begin
          if (!lvl) begin
            m_ph = M_GAP; m_run = 1;
          end else begin
            m_run++;
            if (m_run == LONG_CYC + 1) begin e.l = 1'b1; m_ph = M_HOLD; end
          end
        end
        M_GAP: begin
          if (lvl) begin
            e.d = 1'b1; m_ph = M_P2;
          end else begin
            m_run++;
            if (m_run == DBL_CYC + 1) begin e.s = 1'b1; m_ph = M_IDLE; end
          end
        end
        M_P2:   if (!lvl) m_ph = M_IDLE;
        M_HOLD: if (!lvl) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
      m_prev = lvl;
    end
    e.h = (m_ph == M_HOLD);
    e.b = (m_ph != M_IDLE);
    m_short  += int'(e.s);
    m_long   += int'(e.l);
    m_double += int'(e.d);
  endtask

  task automatic step(input logic lvl, input logic rst);
    exp_t e, got;
    reset    = rst;
    db_level = lvl;
    model(lvl, rst, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    got = {short_press, long_press, double_press, held, busy};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL outputs t=%0t got s%b l%b d%b h%b b%b expected s%b l%b d%b h%b b%b",
               $time, got.s, got.l, got.d, got.h, got.b, e.s, e.l, e.d, e.h, e.b);
    end
    checks++;
    if (!$onehot0({short_press, long_press, double_press})) begin
      errors++;
      $display("FAIL exclusivity t=%0t got s%b l%b d%b expected at most one high",
               $time, short_press, long_press, double_press);
    end
    n_short  += int'(short_press);
    n_long   += int'(long_press);
    n_double += int'(double_press);
    if (busy) any_busy = 1;
  endtask

  task automatic run(input logic lvl, input int n);
    for (int i = 0; i < n; i++) step(lvl, 1'b0);
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int s0, l0, d0;
    logic lvl;

    vecs[0] = '{"short_3",     3, 10, 0,  0, 1, 0, 0};
    vecs[1] = '{"long_9",      9,  5, 0,  0, 0, 1, 0};
    vecs[2] = '{"high_8",      8, 10, 0,  0, 1, 0, 0};
    vecs[3] = '{"double_lo3",  2,  3, 2,  6, 0, 0, 1};
    vecs[4] = '{"short_lo5",   2,  5, 2, 10, 2, 0, 0};
    vecs[5] = '{"double_edge", 2,  4, 2,  6, 0, 0, 1};
    vecs[6] = '{"long_20",    20,  3, 0,  0, 0, 1, 0};
    vecs[7] = '{"short_1",     1, 10, 0,  0, 1, 0, 0};

    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check_int("reset_outputs", int'({short_press, long_press, double_press, held, busy}), 0);

    foreach (vecs[v]) begin
      run(1'b0, 3);
      s0 = n_short; l0 = n_long; d0 = n_double;
      run(1'b1, vecs[v].hi1);
      run(1'b0, vecs[v].lo1);
      run(1'b1, vecs[v].hi2);
      run(1'b0, vecs[v].lo2);
      check_int({vecs[v].name, "_short"},  n_short - s0,  vecs[v].exp_s);
      check_int({vecs[v].name, "_long"},   n_long - l0,   vecs[v].exp_l);
      check_int({vecs[v].name, "_double"}, n_double - d0, vecs[v].exp_d);
    end

    // Reset while held in PRESS1, button kept down afterwards: must stay quiet.
    run(1'b0, 3);
    run(1'b1, 3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    s0 = n_short + n_long + n_double;
    any_busy = 0;
    run(1'b1, 20);
    check_int("held_through_reset_pulses", n_short + n_long + n_double - s0, 0);
    check_int("held_through_reset_busy", any_busy, 0);
    s0 = n_short;
    run(1'b0, 2);
    run(1'b1, 3);
    run(1'b0, 10);
    check_int("resume_after_reset_short", n_short - s0, 1);

    // Reset during the gap abandons the gesture with no pulse.
    s0 = n_short + n_long + n_double;
    run(1'b1, 2);
    run(1'b0, 2);
    step(1'b0, 1'b1);
    run(1'b0, 10);
    check_int("reset_in_gap_pulses", n_short + n_long + n_double - s0, 0);

    // Random level runs with occasional resets.
    lvl = 1'b0;
    for (int c = 0; c < 10000; ) begin
      int len;
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        step(lvl, ($urandom_range(0, 299) == 0));
        c++;
      end
      lvl = ~lvl;
    end
    run(1'b0, 30);
    check_int("random_short_total",  n_short,  m_short);
    check_int("random_long_total",   n_long,   m_long);
    check_int("random_double_total", n_double, m_double);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
